sramlike_ram_responder: RTL
===========================

Name: sramlike_ram_responder

Overview:
- Responder (slave) end of the team's SRAM-like bus: req / wr / size / addr / wdata / rdata / addr_ok / data_ok.
- Used as the on-chip data RAM and as the memory model behind the data cache's miss/write-back port in core-level simulation.
- Handles one transaction at a time, with configurable address-accept and data-return latency.
- Performs byte-lane writes from size and address, and returns full words on reads.

Parameters:
- ADDR_WIDTH, default 10: word-address bits. Depth = 2^ADDR_WIDTH words.
- ADDR_LAT, default 0: cycles req must be held before addr_ok is asserted. Range 0..15.
- DATA_LAT, default 1: cycles from address handshake to the data_ok pulse. Range 1..15.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- data_req  in  1  request valid; held by the initiator until addr_ok.
- data_wr  in  1  1 = write, 0 = read.
- data_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- data_addr  in  32  byte address.
- data_wdata  in  32  write data, in-lane (not shifted).
- data_rdata  out  32  read data; valid only when data_ok=1, otherwise 0.
- data_addr_ok  out  1  address handshake; the transaction is accepted in the cycle where req & addr_ok.
- data_data_ok  out  1  one-cycle completion pulse for reads and writes.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, both counters 0, latched request regs 0.
  - Outputs after reset: addr_ok=0, data_ok=0, rdata=0.
  - RAM contents are not affected by rst.
- FSM states: IDLE, RESP.
- IDLE:
  - acc_cnt increments each cycle while req=1 and acc_cnt<ADDR_LAT.
  - acc_cnt clears whenever req=0. A withdrawn request creates no transaction.
  - addr_ok = (state==IDLE) & req & (acc_cnt==ADDR_LAT). This is combinational, so with ADDR_LAT=0 it asserts in the same cycle as req.
  - On handshake: latch wr, size, addr, wdata; clear acc_cnt; load rsp_cnt=1; go to RESP.
- RESP:
  - addr_ok=0, so requests are not accepted.
  - rsp_cnt increments each cycle.
  - data_ok = (state==RESP) & (rsp_cnt==DATA_LAT), so data_ok is exactly DATA_LAT cycles after the handshake cycle.
  - At the data_ok cycle's posedge: return to IDLE and clear rsp_cnt.
  - Next handshake is no earlier than the cycle after data_ok, with acc_cnt counting from 0 again.
- Write commit:
  - The RAM write happens at the posedge ending the data_ok cycle, using the latched regs.
  - Bytes with write-mask bit 0 are unchanged.
- Read:
  - In the data_ok cycle, rdata = mem[latched word index], full 32 bits, regardless of size.
  - Single outstanding transaction, so a read always sees all earlier committed writes.
- Write mask (from latched size/addr):
  - size 00: one byte lane selected by addr[1:0] (00→0001, 01→0010, 10→0100, 11→1000).
  - size 01: addr[1]=0→0011, addr[1]=1→1100; addr[0] ignored.
  - size 10/11: 1111; addr[1:0] ignored.
- Word index = addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses alias modulo 2^(ADDR_WIDTH+2) bytes.
- Counter width: 4 bits, with saturation not required within the parameter range.
- Inputs other than req are don't-care except in the handshake cycle. Changes during RESP have no effect.
- Reset mid-operation: the pending transaction is dropped. No data_ok is issued and a pending write is not committed.

Test Plan:
- Word write, ADDR_LAT=0, DATA_LAT=1: req wr=1 size=10 addr=0x100 wdata=0xDEADBEEF.
  - addr_ok in the req cycle, data_ok the next cycle.
  - A following read of 0x100 returns rdata=0xDEADBEEF with data_ok one cycle after its handshake.
- Byte/halfword merge, word 0x100 preset to 0x11223344:
  - Write size=00 addr=0x102 wdata=0x00AB0000 → a read of 0x100 returns 0x11AB3344.
  - Then write size=01 addr=0x102 wdata=0xCAFE0000 → a read returns 0xCAFE3344.
- Latency, ADDR_LAT=2 DATA_LAT=3, req held from cycle 0:
  - addr_ok only in cycle 2; data_ok a single pulse in cycle 5.
  - rdata=0 in every cycle except 5.
- Withdrawal, ADDR_LAT=2: req high in cycles 0–1 only, with a write to 0x200 (preset 0x0).
  - No addr_ok, no data_ok, and a read of 0x200 returns 0x0.
  - A new req in cycle 3 gets addr_ok in cycle 5.
- Reset mid-write, DATA_LAT=3: rst=1 one cycle after the handshake of a write 0x55AA55AA to 0x300 (preset 0x12345678).
  - No data_ok afterward; addr_ok=data_ok=0 after reset.
  - A read of 0x300 returns 0x12345678.
- Aliasing, ADDR_WIDTH=10: write 0xA5A5A5A5 to 0x1004 → a read of 0x0004 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/sramlike_ram_responder.sv
// Responder end of the SRAM-like bus backed by a byte-lane-writable word RAM.
// One transaction at a time, with parameterised address-accept and data-return latency.
module sramlike_ram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int ADDR_LAT   = 0,
    parameter int DATA_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    localparam int         DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [3:0] ADDR_LAT_C = 4'(ADDR_LAT);
    localparam logic [3:0] DATA_LAT_C = 4'(DATA_LAT);

    typedef enum logic {IDLE, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              acc_cnt_reg, acc_cnt_next;
    logic [3:0]              rsp_cnt_reg, rsp_cnt_next;
    logic                    wr_reg;
    logic [1:0]              size_reg;
    logic [1:0]              lane_reg;
    logic [ADDR_WIDTH-1:0]   widx_reg;
    logic [31:0]             wdata_reg;
    logic [31:0]             rd_word_reg;
    logic [3:0]              wmask;
    logic                    commit;
    logic                    unused_addr_bits;

    logic [31:0] mem [DEPTH];

    // Upper address bits alias; they are deliberately ignored.
    assign unused_addr_bits = ^data_addr[31:ADDR_WIDTH+2];

    always_comb begin
        state_next   = state_reg;
        acc_cnt_next = acc_cnt_reg;
        rsp_cnt_next = rsp_cnt_reg;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state_reg)
            IDLE: begin
                data_addr_ok = data_req && (acc_cnt_reg == ADDR_LAT_C);
                if (!data_req) begin
                    acc_cnt_next = 4'd0;
                end else if (data_addr_ok) begin
                    acc_cnt_next = 4'd0;
                    rsp_cnt_next = 4'd1;
                    state_next   = RESP;
                end else begin
                    acc_cnt_next = acc_cnt_reg + 4'd1;
                end
            end
            RESP: begin
                data_data_ok = (rsp_cnt_reg == DATA_LAT_C);
                if (data_data_ok) begin
                    rsp_cnt_next = 4'd0;
                    state_next   = IDLE;
                end else begin
                    rsp_cnt_next = rsp_cnt_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            acc_cnt_reg <= 4'd0;
            rsp_cnt_reg <= 4'd0;
            wr_reg      <= 1'b0;
            size_reg    <= 2'b00;
            lane_reg    <= 2'b00;
            widx_reg    <= '0;
            wdata_reg   <= 32'd0;
        end else begin
            state_reg   <= state_next;
            acc_cnt_reg <= acc_cnt_next;
            rsp_cnt_reg <= rsp_cnt_next;
            if (data_addr_ok) begin
                wr_reg    <= data_wr;
                size_reg  <= data_size;
                lane_reg  <= data_addr[1:0];
                widx_reg  <= data_addr[ADDR_WIDTH+1:2];
                wdata_reg <= data_wdata;
            end
        end
    end

    // Byte-lane enables: size[1] selects the whole word, else halfword or byte by address.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign wmask[gi] = size_reg[1] |
                               (size_reg[0] ? (lane_reg[1] == LANE[1]) : (lane_reg == LANE));
        end
    endgenerate

    assign commit = data_data_ok & wr_reg & ~rst;

    // The read word is captured at the handshake; with one outstanding transaction
    // no write can land between then and data_ok.
    always_ff @(posedge clk) begin
        if (data_addr_ok) begin
            rd_word_reg <= mem[data_addr[ADDR_WIDTH+1:2]];
        end
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[widx_reg][8*i +: 8] <= wdata_reg[8*i +: 8];
                end
            end
        end
    end

    assign data_rdata = data_data_ok ? rd_word_reg : 32'd0;

endmodule
